// File: rtl/hwpe_stream_packer_pkg.sv
// hwpe_stream_packer_pkg: shared constants and the flags struct of the narrow-to-wide stream packer.
package hwpe_stream_packer_pkg;
   localparam int unsigned HWPE_STREAM_PACKER_MAX_RATIO = 16;
   localparam int unsigned HWPE_STREAM_PACKER_CNT_W = $clog2(HWPE_STREAM_PACKER_MAX_RATIO);
   // cnt is sized for the largest ratio; the upper bits stay zero for smaller ratios
   typedef struct packed {
      logic [HWPE_STREAM_PACKER_CNT_W-1:0] cnt;
      logic                                busy;
      logic                                flush_pending;
   } flags_packer_t;
endpackage

// File: rtl/hwpe_stream_packer_if.sv
// hwpe_stream_intf_stream: valid/ready stream with byte strobes.
interface hwpe_stream_intf_stream #(parameter int unsigned DATA_WIDTH = 32);
   logic                    valid;
   logic                    ready;
   logic [DATA_WIDTH-1:0]   data;
   logic [DATA_WIDTH/8-1:0] strb;
   modport master (output valid, data, strb, input ready);
   modport slave (input valid, data, strb, output ready);
endinterface

// File: rtl/hwpe_stream_packer.sv
// hwpe_stream_packer: packs RATIO narrow beats into one strobed wide beat, with flush of partial words.
module hwpe_stream_packer
   import hwpe_stream_packer_pkg::*;
#(
   parameter int unsigned DATA_WIDTH_IN  = 32,
   parameter int unsigned DATA_WIDTH_OUT = 128
) (
   input  logic                          clk_i,
   input  logic                          rst_ni,
   input  logic                          clear_i,
   input  logic                          enable_i,
   input  logic                          flush_i,
   hwpe_stream_intf_stream.slave         stream_i,
   hwpe_stream_intf_stream.master        stream_o,
   output flags_packer_t                 flags_o
);
   localparam int unsigned RATIO = DATA_WIDTH_OUT / DATA_WIDTH_IN;
   localparam int unsigned CW    = $clog2(RATIO);
   localparam int unsigned SI    = DATA_WIDTH_IN / 8;
   localparam int unsigned SO    = DATA_WIDTH_OUT / 8;

   if (RATIO < 2 || RATIO > HWPE_STREAM_PACKER_MAX_RATIO || (RATIO & (RATIO - 1)) != 0) begin : g_ratio_check
      $error("hwpe_stream_packer: RATIO must be a power of two in [2, %0d]", HWPE_STREAM_PACKER_MAX_RATIO);
   end

   logic [CW-1:0]             cnt;
   logic [DATA_WIDTH_OUT-1:0] pack_data, out_data, merge_data;
   logic [SO-1:0]             pack_strb, out_strb, merge_strb;
   logic                      out_valid, flush_pending;
   logic                      last, out_free, in_ready, hs, full_emit, flush_req, emit;

   // merge_* is the pack register with the incoming beat already folded in
   always_comb begin
      last       = cnt == CW'(RATIO - 1);
      out_free   = ~out_valid | stream_o.ready;
      in_ready   = enable_i & ~flush_pending & ~(last & ~out_free);
      hs         = stream_i.valid & in_ready;
      full_emit  = hs & last;
      flush_req  = (flush_i | flush_pending) & ~full_emit & (hs | (cnt != '0));
      emit       = full_emit | (flush_req & out_free);
      merge_data = pack_data;
      merge_strb = pack_strb;
      if (hs) begin
         merge_data[cnt*DATA_WIDTH_IN +: DATA_WIDTH_IN] = stream_i.data;
         merge_strb[cnt*SI +: SI]                       = stream_i.strb;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         cnt           <= '0;
         pack_data     <= '0;
         pack_strb     <= '0;
         out_valid     <= 1'b0;
         out_data      <= '0;
         out_strb      <= '0;
         flush_pending <= 1'b0;
      end else if (clear_i) begin
         cnt           <= '0;
         pack_data     <= '0;
         pack_strb     <= '0;
         out_valid     <= 1'b0;
         out_data      <= '0;
         out_strb      <= '0;
         flush_pending <= 1'b0;
      end else begin
         if (emit) begin
            out_valid <= 1'b1;
            out_data  <= merge_data;
            out_strb  <= merge_strb;
            cnt       <= '0;
            pack_strb <= '0;
         end else begin
            if (stream_o.ready) out_valid <= 1'b0;
            if (hs) begin
               cnt       <= cnt + CW'(1);
               pack_data <= merge_data;
               pack_strb <= merge_strb;
            end
         end
         // a pending flush never sees new input, so it stays requested until the output frees up
         flush_pending <= flush_req & ~out_free;
      end
   end

   assign stream_i.ready        = in_ready;
   assign stream_o.valid        = out_valid;
   assign stream_o.data         = out_data;
   assign stream_o.strb         = out_strb;
   assign flags_o.cnt           = HWPE_STREAM_PACKER_CNT_W'(cnt);
   assign flags_o.busy          = out_valid | (cnt != '0) | flush_pending;
   assign flags_o.flush_pending = flush_pending;

   a_out_stable: assert property (@(posedge clk_i) disable iff (!rst_ni)
      out_valid && !stream_o.ready && !clear_i |=> out_valid && $stable(out_data) && $stable(out_strb));
   a_no_empty_beat: assert property (@(posedge clk_i) disable iff (!rst_ni) out_valid |-> out_strb != '0);
   a_cnt_range: assert property (@(posedge clk_i) disable iff (!rst_ni) 32'(cnt) < RATIO);
endmodule
